// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants for the round-robin scheduled 8:1 word multiplexer.
//   N     : number of requesters (fixed at 8 to match the mux width)
//   W     : data word width
//   SELW  : select / pointer width
//   StEmpty/StFull : output register state encoding (out_valid == state)
package mux8_rr_sched_pkg;

  localparam int unsigned N    = 8;
  localparam int unsigned W    = 16;
  localparam int unsigned SELW = 3;

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  // One-hot vector with bit idx set.
  function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 word multiplexer, purely combinational.
//   a0..a7 : input words
//   s      : select
//   o      : selected word
module mux8 #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] a2,
  input  logic [W-1:0] a3,
  input  logic [W-1:0] a4,
  input  logic [W-1:0] a5,
  input  logic [W-1:0] a6,
  input  logic [W-1:0] a7,
  input  logic [2:0]   s,
  output logic [W-1:0] o
);

  always_comb begin
    o = '0;
    unique case (s)
      3'd0: o = a0;
      3'd1: o = a1;
      3'd2: o = a2;
      3'd3: o = a3;
      3'd4: o = a4;
      3'd5: o = a5;
      3'd6: o = a6;
      3'd7: o = a7;
      default: o = '0;
    endcase
  end

endmodule

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Round-robin priority picker over eight eligibility bits.
//   elig   : eligible requesters
//   ptr    : index holding highest priority this cycle
//   winner : first set bit found searching upward from ptr, wrapping 7->0;
//            equals ptr when nothing is eligible
//   any    : at least one eligible requester
module rr_pick8
  import mux8_rr_sched_pkg::*;
(
  input  logic [N-1:0]    elig,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] winner,
  output logic            any
);

  logic [SELW-1:0] idx;
  logic            found;

  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // 3-bit add wraps naturally from 7 back to 0.
      idx = ptr + SELW'(i);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |elig;

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing one 8:1 word mux among eight requesters.
// The winning word is captured into a single-entry output register with a
// valid/ready handshake; the winner gets a one-cycle gnt pulse aligned with
// the captured word becoming visible.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req, req_mask       : level requests and per-requester eligibility
//   a0..a7              : requester data words
//   gnt                 : registered one-hot grant pulse
//   sel                 : combinational mux select from arbitration
//   out_data/out_src    : registered word and its requester index
//   out_valid/out_ready : output handshake
module mux8_rr_sched
  import mux8_rr_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_mask,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    a2,
  input  logic [W-1:0]    a3,
  input  logic [W-1:0]    a4,
  input  logic [W-1:0]    a5,
  input  logic [W-1:0]    a6,
  input  logic [W-1:0]    a7,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_src,
  output logic            out_valid,
  input  logic            out_ready
);

  logic            state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] src_q, src_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic [N-1:0]    elig;
  logic [SELW-1:0] winner;
  logic            any;
  logic [W-1:0]    mux_o;
  logic            load;

  assign elig = req & req_mask;

  rr_pick8 u_pick (
    .elig   (elig),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign sel = winner;

  mux8 #(
    .W (W)
  ) u_mux (
    .a0 (a0),
    .a1 (a1),
    .a2 (a2),
    .a3 (a3),
    .a4 (a4),
    .a5 (a5),
    .a6 (a6),
    .a7 (a7),
    .s  (sel),
    .o  (mux_o)
  );

  // A new word may be captured when the register is empty or being drained
  // this same edge, which gives one word per cycle with no bubble.
  assign load = any && ((state_q == StEmpty) || out_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    gnt_d   = '0;
    ptr_d   = ptr_q;
    if (load) begin
      state_d = StFull;
      data_d  = mux_o;
      src_d   = sel;
      gnt_d   = onehot(sel);
      ptr_d   = sel + SELW'(1);
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
      src_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign gnt       = gnt_q;

endmodule

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
- Round-robin scheduler that shares the 8:1, 16-bit word multiplexer datapath among eight requesters.
- Each cycle it picks one eligible requester and drives the mux select. The selected word is captured into a single-entry output register with a valid/ready handshake.
- The chosen requester receives a one-cycle grant pulse meaning "your word was taken".
- Sits between eight word producers and one downstream consumer.

Parameters:
- N, 8, number of requesters; fixed at 8 to match the mux width.
- W, 16, data word width.
- SELW, 3, select width (log2 N).

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  level request per requester; held until granted
- req_mask  input  N  1 = requester eligible; sampled every cycle
- a0..a7  input  W each  requester data words, stable while req is high
- gnt  output  N  one-hot, one-cycle pulse; word of that requester captured this edge
- sel  output  SELW  select currently driven into the mux (combinational, from arbitration)
- out_data  output  W  registered selected word
- out_src  output  SELW  index of the requester that produced out_data
- out_valid  output  1  out_data/out_src hold an unconsumed word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready at a clock edge

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_src=0, gnt=0.
  - Round-robin pointer ptr=0, so requester 0 has highest priority.
  - FSM state = EMPTY.
- Eligibility: elig = req & req_mask.
- Arbitration (combinational):
  - Search elig starting at index ptr, wrapping 7 to 0. The first set bit is the winner.
  - sel = winner index. If elig is 0, sel = ptr, so the mux input is don't-care but defined.
- Load condition: load = (elig != 0) && (!out_valid || out_ready).
- On a load edge:
  - out_data <= mux output for sel; out_src <= sel; out_valid <= 1.
  - gnt[sel] <= 1 for exactly one cycle. gnt is registered and asserts the cycle after the capture edge, aligned with out_valid rising.
  - ptr <= (sel+1) mod 8. The winner drops to lowest priority next round.
- No-load edge:
  - out_valid && out_ready: out_valid <= 0.
  - Otherwise: out_valid, out_data and out_src hold.
  - gnt <= 0. ptr unchanged.
- FSM:
  - EMPTY --load--> FULL.
  - FULL --out_ready && load--> FULL. Back-to-back: one word per cycle throughput.
  - FULL --out_ready && !load--> EMPTY.
  - FULL --!out_ready--> FULL. The word is held; no new grant is issued.
  - out_valid == (state==FULL).
- Backpressure: while out_valid && !out_ready:
  - out_data and out_src are stable; gnt stays 0.
  - Requests accumulate and are served later in round-robin order.
- Latency: request seen at edge k gives out_valid and gnt at edge k (visible after k). Zero-bubble when the consumer is always ready.
- Requesters:
  - Must deassert req (or present their next word) on the cycle they see gnt.
  - If req stays high, the requester is served again only after the others in rotation.
- Masked requesters are never granted, even if they are the only req. A mask change takes effect in the same cycle's arbitration.
- Single requester continuously active and consumer always ready: granted every cycle, since ptr wraps past it and returns.
- Reset mid-transfer: the pending word is discarded, out_valid drops immediately, ptr returns to 0.
- Widths: sel, ptr and out_src are 3-bit; the mod-8 wrap is natural overflow.

Decomposition:
- Shared package holds:
  - Constants N=8, W=16, SELW=3.
  - FSM state encoding: EMPTY=1'b0, FULL=1'b1.
- Sub-module: instantiate the existing mux8 (ports: o, s, a0..a7) as the datapath, driven by sel.
- The round-robin priority picker is a natural separate sub-module, rr_pick8: inputs elig and ptr; outputs winner index and any.

Test Plan:
- Reset then idle: rst_n low 2 cycles, a_i = i, req=0 -> out_valid=0, gnt=0, out_data=0, out_src=0, sel=0.
- All requesting, mask=8'hFF, out_ready=1, a_i = 16'h0100+i, req held high -> out_src sequence 0,1,2,...,7,0, out_data 0x0100..0x0107, gnt walks one-hot 01,02,04..80, one word per cycle.
- Backpressure: req=8'b0000_0110, out_ready=0 for 5 cycles -> first word out_src=1, data 0x0101 held, gnt pulses once then stays 0. Raise out_ready -> next cycle out_src=2.
- Mask: req=8'hFF, req_mask=8'b1000_0001, out_ready=1 -> out_src alternates 0,7,0,7; gnt never hits bits 1..6.
- Wrap fairness: after grant to 7, req=8'b1000_0001 -> next grant is 0, then 7.
- Async reset mid-stream: during the all-request sequence, pull rst_n low between edges -> out_valid drops without a clock. After release, first grant is requester 0.
